mem_port_arbiter: RTL and testbench

Arbiter and access sequencer that shares the CPU's single-port unified memory between the instruction-fetch stage and the memory stage (LDR/STR). It accepts one request at a time, drives the memory for a fixed access latency, and returns a one-cycle response pulse to the winner. The per-port `valid` outputs are the stall-release signals for the Fetch and Memory pipeline stages. Data accesses have priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and the
// load/store stage. One access in flight at a time; data has priority,
// with a streak limit so fetch cannot be starved.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; arbitrate between pending requests
// ACCESS | memory driven from captured request for LAT cycles
// RESP   | one-cycle completion pulse to the winner, then back to IDLE
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            win_q, win_d;        // 1 = data port, 0 = fetch port
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic            grant_data;

  // Next-state, grant capture and completion decision.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    grant_data = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Fetch only overrides a data request once the streak limit is hit.
          grant_data = d_req && !(if_req && (streak_q == STREAK_MAX));
          win_d      = grant_data;
          if (grant_data) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            streak_d = '0;
          end
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (win_q) d_rdata_d  = mem_rdata;
            else       if_rdata_d = mem_rdata;
          end
          // Registered here so valid has no combinational path from req;
          // a requester that has already dropped req gets no pulse.
          if_valid_d = !win_q && if_req;
          d_valid_d  = win_q && d_req;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // Memory bus is only driven in ACCESS; quiet (all zero) otherwise.
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = mem_en && we_q;
    mem_addr  = mem_en ? addr_q  : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    busy      = (state_q != IDLE);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if_valid  = if_valid_q;
    d_valid   = d_valid_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
  localparam int MAX_STREAK = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: cycles elapsed since the grant (0 = idle, 1..LAT = memory access,
  // LAT+1 = response cycle) plus the captured transaction.
  int          m_phase = 0;
  bit          m_win = 0;
  logic [31:0] m_addr = '0;
  bit          m_we = 0;
  logic [31:0] m_wdata = '0;
  int          m_streak = 0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  bit          m_if_valid = 0;
  bit          m_d_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit data_wins;
    if (reset) begin
      m_phase = 0; m_streak = 0; m_win = 0;
      m_addr = '0; m_we = 0; m_wdata = '0;
      m_if_rdata = '0; m_d_rdata = '0;
      m_if_valid = 0; m_d_valid = 0;
      return;
    end
    m_if_valid = 0;
    m_d_valid  = 0;
    if (m_phase == 0) begin
      if (if_req || d_req) begin
        data_wins = d_req && !(if_req && m_streak == MAX_STREAK);
        m_win = data_wins;
        if (data_wins) begin
          m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_streak = if_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
        end else begin
          m_addr = if_addr; m_we = 0; m_wdata = '0;
          m_streak = 0;
        end
        m_phase = 1;
      end
    end else if (m_phase <= LAT) begin
      if (m_phase == LAT) begin
        if (!m_we) begin
          if (m_win) m_d_rdata = mem_rdata;
          else       m_if_rdata = mem_rdata;
        end
        m_if_valid = !m_win && if_req;
        m_d_valid  = m_win && d_req;
      end
      m_phase++;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    bit acc;
    acc = (m_phase >= 1) && (m_phase <= LAT);
    chk("mem_en",    {31'b0, mem_en},   {31'b0, acc});
    chk("mem_we",    {31'b0, mem_we},   {31'b0, acc && m_we});
    chk("mem_addr",  mem_addr,          acc ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata,         acc ? m_wdata : 32'h0);
    chk("busy",      {31'b0, busy},     {31'b0, m_phase != 0});
    chk("if_valid",  {31'b0, if_valid}, {31'b0, m_if_valid});
    chk("d_valid",   {31'b0, d_valid},  {31'b0, m_d_valid});
    chk("if_rdata",  if_rdata,          m_if_rdata);
    chk("d_rdata",   d_rdata,           m_d_rdata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0;
  endtask

  task automatic rand_drive();
    if (if_valid || (if_req && $urandom_range(0, 49) == 0)) begin
      if_req = 0;
    end else if (!if_req && $urandom_range(0, 1) == 1) begin
      if_req  = 1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_valid || (d_req && $urandom_range(0, 49) == 0)) begin
      d_req = 0;
    end else if (!d_req && $urandom_range(0, 1) == 1) begin
      d_req   = 1;
      d_we    = ($urandom_range(0, 2) == 0);
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
    end
    mem_rdata = $urandom;
    reset = ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    int dv, iv, fg, cnt, vcnt, b3, b4, g;
    logic prev_en;

    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset state
    cycle();
    cycle();
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 0;
    cycle();

    // Lone fetch
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'hE3A0_1005;
    cycle();
    chk("lf_c1_en", {31'b0, mem_en}, 32'h1);
    chk("lf_c1_addr", mem_addr, 32'h40);
    chk("lf_c1_busy", {31'b0, busy}, 32'h1);
    cycle();
    chk("lf_c2_en", {31'b0, mem_en}, 32'h1);
    cycle();
    chk("lf_c3_en", {31'b0, mem_en}, 32'h0);
    chk("lf_c3_valid", {31'b0, if_valid}, 32'h1);
    chk("lf_c3_rdata", if_rdata, 32'hE3A0_1005);
    chk("lf_c3_busy", {31'b0, busy}, 32'h1);
    if_req = 0;
    cycle();
    chk("lf_c4_busy", {31'b0, busy}, 32'h0);

    // Simultaneous fetch and load: data first
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
    mem_rdata = 32'hCAFE_0100;
    dv = -1; iv = -1; fg = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (d_valid && dv < 0) begin dv = c; d_req = 0; end
      if (if_valid && iv < 0) begin iv = c; if_req = 0; end
      if (mem_en && mem_addr == 32'h40 && fg < 0) fg = c;
    end
    chk("sim_d_valid_cycle", 32'(dv), 32'd3);
    chk("sim_fetch_access_cycle", 32'(fg), 32'd5);
    chk("sim_if_valid_cycle", 32'(iv), 32'd7);
    chk("sim_d_rdata", d_rdata, 32'hCAFE_0100);

    // Store
    d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
    cnt = 0; vcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (mem_we && mem_addr == 32'h104 && mem_wdata == 32'hDEAD_BEEF) cnt++;
      if (d_valid) begin vcnt++; d_req = 0; end
    end
    d_we = 0;
    chk("st_we_cycles", 32'(cnt), 32'd2);
    chk("st_d_valid_count", 32'(vcnt), 32'd1);
    chk("st_d_rdata_kept", d_rdata, 32'hCAFE_0100);

    // Starvation guard: both requests held high continuously
    d_req = 1; d_we = 0; d_addr = 32'h200; if_req = 1; if_addr = 32'h300;
    prev_en = 0; g = 0;
    for (int c = 1; c <= 64; c++) begin
      cycle();
      if (mem_en && !prev_en && g < 15) begin
        chk($sformatf("starve_grant%0d", g), mem_addr,
            (g % 5 == 4) ? 32'h300 : 32'h200);
        g++;
      end
      prev_en = mem_en;
    end
    chk("starve_grant_count", 32'(g), 32'd15);
    idle_inputs();
    for (int c = 0; c < 6; c++) cycle();

    // Abandoned fetch
    if_req = 1; if_addr = 32'h500;
    cycle();
    cnt = mem_en ? 1 : 0;
    if_req = 0;
    vcnt = 0; b3 = -1; b4 = -1;
    for (int c = 2; c <= 6; c++) begin
      cycle();
      if (mem_en) cnt++;
      if (if_valid) vcnt++;
      if (c == 3) b3 = busy;
      if (c == 4) b4 = busy;
    end
    chk("ab_mem_en_cycles", 32'(cnt), 32'd2);
    chk("ab_no_valid", 32'(vcnt), 32'd0);
    chk("ab_busy_resp", 32'(b3), 32'd1);
    chk("ab_idle_after", 32'(b4), 32'd0);

    // Reset mid-access
    d_req = 1; d_we = 0; d_addr = 32'h600; mem_rdata = 32'h66;
    cycle();
    chk("rm_in_access", {31'b0, mem_en}, 32'h1);
    reset = 1; d_req = 0;
    cycle();
    reset = 0;
    chk("rm_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rm_busy", {31'b0, busy}, 32'h0);
    chk("rm_mem_addr", mem_addr, 32'h0);
    chk("rm_d_rdata", d_rdata, 32'h0);
    chk("rm_if_rdata", if_rdata, 32'h0);
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (d_valid || if_valid) vcnt++;
    end
    chk("rm_no_valid", 32'(vcnt), 32'd0);
    d_req = 1; d_addr = 32'h604; mem_rdata = 32'h77;
    dv = -1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (d_valid && dv < 0) begin dv = c; d_req = 0; end
    end
    chk("rm_fresh_latency", 32'(dv), 32'd3);
    chk("rm_fresh_rdata", d_rdata, 32'h77);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
